mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single SRAM-like memory bus between the fetch port (IF, read-only) and the load/store port (MEM, read/write).
- One transaction is outstanding at a time: an address phase (req/addr_ok) followed by a data phase (data_ok).
- Produces one-cycle completion pulses per port and a global stall request consumed by the hazard unit, so both pipeline stages freeze until their access completes.
- Sits between the datapath's fetch/memory stages and the bus bridge.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_MAX, 3, consecutive data grants allowed while a fetch is waiting before the fetch is forced next (range 1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- inst_req  in  1  fetch request; held high until inst_done.
- inst_addr  in  AW  fetch address.
- inst_rdata  out  DW  fetched word; valid only while inst_done=1.
- inst_done  out  1  one-cycle completion pulse for the fetch port.
- data_req  in  1  load/store request; held high until data_done.
- data_wr  in  1  1=store, 0=load.
- data_size  in  2  0=byte, 1=half, 2=word.
- data_addr  in  AW  load/store address.
- data_wdata  in  DW  store data.
- data_rdata  out  DW  load result; valid only while data_done=1.
- data_done  out  1  one-cycle completion pulse for the data port.
- bus_req  out  1  bus address-phase request.
- bus_wr  out  1  bus write enable.
- bus_size  out  2  bus access size.
- bus_addr  out  AW  bus address.
- bus_wdata  out  DW  bus write data.
- bus_addr_ok  in  1  address accepted this cycle.
- bus_data_ok  in  1  data phase complete this cycle.
- bus_rdata  in  DW  bus read data; valid with bus_data_ok.
- stall_req  out  1  pipeline freeze request.

Behaviour:
- States:
  - IDLE
  - ADDR: bus_req=1, owner latched.
  - DATA: waiting for bus_data_ok.
- Registered state: owner (INST/DATA) and starve_cnt (4 bits).
- Reset values: state=IDLE, owner=INST, starve_cnt=0. All outputs 0 (rdata outputs also 0).
- IDLE:
  - If data_req and (~inst_req or starve_cnt<STARVE_MAX), grant DATA.
  - Else if inst_req, grant INST.
  - Else stay in IDLE.
  - On grant: latch addr/wr/size/wdata from the winning port into bus registers and move to ADDR.
  - Fetch grants drive bus_wr=0 and bus_size=2.
- starve_cnt:
  - Increments (saturating at 15) on a DATA grant while inst_req=1.
  - Clears on any INST grant.
  - Clears on a DATA grant with inst_req=0.
- ADDR:
  - bus_req=1, with bus fields taken from the latched registers (stable regardless of requester changes).
  - On bus_addr_ok, move to DATA and drop bus_req the next cycle.
- DATA:
  - On bus_data_ok, move to IDLE.
  - Pulse the owner's done for exactly that cycle; its rdata = bus_rdata (combinational pass-through, zero added latency).
  - Stores also pulse data_done; data_rdata is don't-care for stores.
- Same-cycle addr_ok and data_ok in ADDR are not permitted by the bus protocol. No handling is required; the bench asserts it never occurs.
- Abandoned request: if the owner's req drops (pipeline flush) in ADDR or DATA, the transaction still completes on the bus. The done pulse is suppressed and the data is discarded.
- Back-to-back transactions: IDLE always lasts at least one cycle between transactions. Minimum transaction is 3 cycles (grant, addr_ok, data_ok).
- stall_req = (inst_req & ~inst_done) | (data_req & ~data_done). It is combinational and 0 during reset.
- Mid-operation reset: returns to IDLE immediately; the in-flight bus transaction is abandoned.

Decomposition:
- Shared package (defines.h), constants:
  - ARB_IDLE, ARB_ADDR, ARB_DATA state encodings.
  - OWN_INST, OWN_DATA owner encodings.
  - SIZE_BYTE, SIZE_HALF, SIZE_WORD bus size encodings.
- One sub-module: arb_pick. It is combinational; it takes inst_req, data_req, starve_cnt and STARVE_MAX and returns grant_valid and grant_owner.
- FSM and registers stay in the top module.

Test Plan:
- Fetch only: inst_req=1, addr=0xBFC00000; addr_ok in cycle 2, data_ok in cycle 4 with rdata=0x3C08BFAF -> inst_done pulses once with inst_rdata=0x3C08BFAF; stall_req low the cycle after.
- Simultaneous requests: inst_req and data_req rise together, store word 0xDEADBEEF to 0x80000010 -> data granted first with bus_wr=1, bus_size=2; then fetch; two done pulses in data, inst order.
- Starvation: inst_req held and data_req re-asserted continuously, STARVE_MAX=3 -> exactly 3 data transactions, then 1 fetch, then data again; starve_cnt returns to 0 after the fetch.
- Flush mid-transaction: data load granted, data_req drops during DATA -> bus completes, data_done stays 0, FSM returns to IDLE, next inst_req is granted normally.
- Bus stalls: addr_ok delayed 5 cycles, then data_ok delayed 7 cycles -> bus_addr/size/wdata stable throughout ADDR; stall_req high for the whole interval.
- Reset during DATA: rst low for 1 cycle -> bus_req=0, both done=0, state IDLE immediately; a new fetch after release completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/load-store memory port arbiter.
// Used by the arbiter top, its grant picker, and anything observing the bus.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arbState_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [3:0] STARVE_SAT = 4'd15;

  function automatic logic [3:0] satInc(input logic [3:0] cnt);
    return (cnt == STARVE_SAT) ? cnt : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side fetch/load-store ports plus the shared SRAM-like bus.
// master = arbiter view, slave = datapath/bus-bridge view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          inst_done;

  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [DW-1:0] data_rdata;
  logic          data_done;

  logic          bus_req;
  logic          bus_wr;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok;
  logic          bus_data_ok;
  logic [DW-1:0] bus_rdata;

  logic          stall_req;

  modport master (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata,
    output inst_rdata, inst_done, data_rdata, data_done,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    output stall_req
  );

  modport slave (
    output inst_req, inst_addr,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata,
    input  inst_rdata, inst_done, data_rdata, data_done,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    input  stall_req
  );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational grant choice between fetch and load/store; zero latency, no state.
// Data wins unless a fetch has waited through STARVE_MAX consecutive data grants.
module arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic       instReq,
  input  logic       dataReq,
  input  logic [3:0] starveCnt,
  output logic       grantValid,
  output owner_e     grantOwner
);

  localparam logic [3:0] LIMIT = 4'(STARVE_MAX);

  always_comb begin
    grantValid = instReq | dataReq;
    grantOwner = (dataReq && (!instReq || (starveCnt < LIMIT))) ? OWN_DATA : OWN_INST;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like bus between fetch and load/store; one transaction in flight,
// min 3 cycles (grant, addr_ok, data_ok); done/rdata pass through combinationally on data_ok.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.master ifc
);

  arbState_e     state, stateNext;
  owner_e        owner, grantOwner;
  logic          grantValid;
  logic          grantTake;
  logic          finish;
  logic          ownerReq;
  logic          abandoned;
  logic          instDone, dataDone;
  logic [3:0]    starveCnt;
  logic [AW-1:0] regAddr;
  logic [DW-1:0] regWdata;
  logic          regWr;
  logic [1:0]    regSize;

  arb_pick #(.STARVE_MAX(STARVE_MAX)) uPick (
    .instReq    (ifc.inst_req),
    .dataReq    (ifc.data_req),
    .starveCnt  (starveCnt),
    .grantValid (grantValid),
    .grantOwner (grantOwner)
  );

  assign grantTake = (state == ARB_IDLE) && grantValid;
  assign finish    = (state == ARB_DATA) && ifc.bus_data_ok;
  assign ownerReq  = (owner == OWN_INST) ? ifc.inst_req : ifc.data_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      ARB_IDLE: if (grantValid)      stateNext = ARB_ADDR;
      ARB_ADDR: if (ifc.bus_addr_ok) stateNext = ARB_DATA;
      ARB_DATA: if (ifc.bus_data_ok) stateNext = ARB_IDLE;
      default:                       stateNext = ARB_IDLE;
    endcase
  end

  // Bus fields are frozen at grant so requester changes during ADDR cannot leak onto the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_INST;
      starveCnt <= '0;
      regAddr   <= '0;
      regWdata  <= '0;
      regWr     <= 1'b0;
      regSize   <= '0;
      abandoned <= 1'b0;
    end else if (grantTake) begin
      owner     <= grantOwner;
      abandoned <= 1'b0;
      if (grantOwner == OWN_DATA) begin
        regAddr   <= ifc.data_addr;
        regWdata  <= ifc.data_wdata;
        regWr     <= ifc.data_wr;
        regSize   <= ifc.data_size;
        starveCnt <= ifc.inst_req ? satInc(starveCnt) : '0;
      end else begin
        regAddr   <= ifc.inst_addr;
        regWdata  <= '0;
        regWr     <= 1'b0;
        regSize   <= SIZE_WORD;
        starveCnt <= '0;
      end
    end else if ((state != ARB_IDLE) && !ownerReq) begin
      // A flushed requester must not see a done even if it re-requests before data_ok.
      abandoned <= 1'b1;
    end
  end

  always_comb begin
    instDone = finish && (owner == OWN_INST) && ifc.inst_req && !abandoned;
    dataDone = finish && (owner == OWN_DATA) && ifc.data_req && !abandoned;

    ifc.bus_req    = (state == ARB_ADDR);
    ifc.bus_wr     = regWr;
    ifc.bus_size   = regSize;
    ifc.bus_addr   = regAddr;
    ifc.bus_wdata  = regWdata;

    ifc.inst_done  = instDone;
    ifc.data_done  = dataDone;
    ifc.inst_rdata = instDone ? ifc.bus_rdata : '0;
    ifc.data_rdata = dataDone ? ifc.bus_rdata : '0;

    ifc.stall_req  = rst_n && ((ifc.inst_req && !instDone) || (ifc.data_req && !dataDone));
  end

endmodule
